// File: rtl/cpu_ctrl_fsm_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_fsm_pkg
// Shared types and constants for the RV32I multicycle control unit:
//   - alu_opcode_t : operation select consumed by the ALU (op_sel interface)
//   - ctrl_state_t : control FSM state encoding
//   - RV32I major opcode constants
//   - datapath mux-select encodings (alu_src_a/b, result_src, imm_src)
//   - is_illegal_instr(): classifies opcode/funct3 pairs the core rejects
// ---------------------------------------------------------------------------
package cpu_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_opcode_t;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWRITE,
        S_MEMWB,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL_PRE,
        S_JAL,
        S_JALR,
        S_LUI,
        S_AUIPC,
        S_HALT
    } ctrl_state_t;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Only word-sized loads/stores are supported by this datapath
    localparam logic [2:0] F3_WORD = 3'b010;

    // ALU operand A select
    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RD1   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRC_B_RD2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Immediate format select
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Unknown opcodes, non-word loads/stores and the two unused branch
    // funct3 codes (010/011) are not executed by this core.
    function automatic logic is_illegal_instr(input logic [6:0] op, input logic [2:0] f3);
        logic bad;
        case (op)
            OP_LOAD, OP_STORE: bad = (f3 != F3_WORD);
            OP_BRANCH:         bad = (f3[2:1] == 2'b01);
            OP_OP, OP_OPIMM, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: bad = 1'b0;
            default:           bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_alu_decoder.sv
// ---------------------------------------------------------------------------
// cpu_alu_decoder
// Combinational ALU operation decode for R-type and I-type arithmetic.
// Ports:
//   funct3    in  3             instr[14:12]
//   funct7b5  in  1             instr[30]
//   is_rtype  in  1             1 = register-register form (enables SUB)
//   alu_op    out alu_opcode_t  decoded ALU operation
// ---------------------------------------------------------------------------
module cpu_alu_decoder
    import cpu_ctrl_fsm_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        is_rtype,
    output alu_opcode_t alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            // instr[30] is part of the immediate for ADDI, so it only
            // selects SUB in the register form.
            3'b000: alu_op = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: alu_op = ALU_SLL;
            3'b010: alu_op = ALU_SLT;
            3'b011: alu_op = ALU_SLTU;
            3'b100: alu_op = ALU_XOR;
            // SRAI/SRLI carry the arithmetic bit in instr[30] as well
            3'b101: alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_op = ALU_OR;
            3'b111: alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_fsm
// Multicycle main control unit for the RV32I core. Sequences fetch, decode,
// execute, memory and writeback one state per clock, drives the datapath
// mux selects / write enables and the memory request handshake, and produces
// the ALU operation select.
//
// Optional build macro: CPU_CTRL_ILLEGAL_TRAP_EN
//   defined   : illegal instructions set sticky illegal_instr and halt
//   undefined : illegal instructions retire as NOPs, illegal_instr = 0
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   synchronous active-low reset
//   opcode/funct3/funct7b5  in  instruction fields from the IR
//   z_flag         in   ALU zero flag (same cycle)
//   mem_ready      in   memory accepts/completes the current request
//   mem_req/mem_we/adr_src  out  memory request handshake
//   ir_we/pc_we/reg_we      out  datapath write enables
//   alu_src_a/alu_src_b/result_src/imm_src  out  datapath mux selects
//   alu_op_sel     out  ALU operation
//   instr_retired  out  1-cycle pulse on entering FETCH
//   mem_timeout    out  sticky, memory wait limit expired
//   illegal_instr  out  sticky, illegal instruction trapped
// ---------------------------------------------------------------------------
module cpu_ctrl_fsm
    import cpu_ctrl_fsm_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 255,
    parameter int WAIT_CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        z_flag,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [2:0]  imm_src,
    output alu_opcode_t alu_op_sel,
    output logic        instr_retired,
    output logic        mem_timeout,
    output logic        illegal_instr
);

    ctrl_state_t           state_reg, state_next;
    logic [WAIT_CNT_W-1:0] wait_cnt_reg, wait_cnt_next, wait_inc;
    logic                  timeout_reg, timeout_set;
    logic                  retire_reg;
    alu_opcode_t           dec_op;

    assign wait_inc = wait_cnt_reg + WAIT_CNT_W'(1);

    cpu_alu_decoder u_alu_dec (
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .is_rtype (state_reg == S_EXEC_R),
        .alu_op   (dec_op)
    );

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    logic illegal_reg;
    logic illegal_set;
`endif

    // Next-state and output decode. Everything stays at its default while
    // rst_n is low so a reset aborts an in-flight request in the same cycle.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        timeout_set   = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        adr_src       = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        reg_we        = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_src    = 2'b00;
        imm_src       = 3'b000;
        alu_op_sel    = ALU_ADD;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        illegal_set   = 1'b0;
`endif
        if (rst_n) begin
            case (state_reg)
                S_FETCH: begin
                    mem_req = 1'b1;
                    adr_src = 1'b0;
                    // PC+4 goes straight to the PC from the ALU output
                    if (mem_ready) begin
                        ir_we      = 1'b1;
                        pc_we      = 1'b1;
                        alu_src_a  = SRC_A_PC;
                        alu_src_b  = SRC_B_FOUR;
                        result_src = RES_ALU;
                        state_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Branch target is computed speculatively and held in ALUOUT
                    alu_src_a = SRC_A_OLDPC;
                    alu_src_b = SRC_B_IMM;
                    imm_src   = IMM_B;
                    if (is_illegal_instr(opcode, funct3)) begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                        illegal_set = 1'b1;
                        state_next  = S_HALT;
`else
                        state_next  = S_FETCH;
`endif
                    end else begin
                        case (opcode)
                            OP_LOAD, OP_STORE: state_next = S_MEMADR;
                            OP_OP:             state_next = S_EXEC_R;
                            OP_OPIMM:          state_next = S_EXEC_I;
                            OP_BRANCH:         state_next = S_BRANCH;
                            OP_JAL:            state_next = S_JAL_PRE;
                            OP_JALR:           state_next = S_JALR;
                            OP_LUI:            state_next = S_LUI;
                            OP_AUIPC:          state_next = S_AUIPC;
                            default:           state_next = S_FETCH;
                        endcase
                    end
                end
                S_MEMADR: begin
                    alu_src_a  = SRC_A_RD1;
                    alu_src_b  = SRC_B_IMM;
                    imm_src    = (opcode == OP_STORE) ? IMM_S : IMM_I;
                    state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    mem_req    = 1'b1;
                    adr_src    = 1'b1;
                    result_src = RES_ALUOUT;
                    if (mem_ready) state_next = S_MEMWB;
                end
                S_MEMWRITE: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) state_next = S_FETCH;
                end
                S_MEMWB: begin
                    result_src = RES_DATA;
                    reg_we     = 1'b1;
                    state_next = S_FETCH;
                end
                S_EXEC_R: begin
                    alu_src_a  = SRC_A_RD1;
                    alu_src_b  = SRC_B_RD2;
                    alu_op_sel = dec_op;
                    state_next = S_ALUWB;
                end
                S_EXEC_I: begin
                    alu_src_a  = SRC_A_RD1;
                    alu_src_b  = SRC_B_IMM;
                    imm_src    = IMM_I;
                    alu_op_sel = dec_op;
                    state_next = S_ALUWB;
                end
                S_ALUWB: begin
                    result_src = RES_ALUOUT;
                    reg_we     = 1'b1;
                    state_next = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a  = SRC_A_RD1;
                    alu_src_b  = SRC_B_RD2;
                    result_src = RES_ALUOUT;
                    case (funct3[2:1])
                        2'b10:   alu_op_sel = ALU_SLT;
                        2'b11:   alu_op_sel = ALU_SLTU;
                        default: alu_op_sel = ALU_SUB;
                    endcase
                    // funct3[0] inverts the sense within each pair; the
                    // less-than pairs (BLT/BLTU) take on z=0, hence funct3[2].
                    pc_we      = z_flag ^ funct3[0] ^ funct3[2];
                    state_next = S_FETCH;
                end
                S_JAL_PRE: begin
                    alu_src_a  = SRC_A_OLDPC;
                    alu_src_b  = SRC_B_IMM;
                    imm_src    = IMM_J;
                    state_next = S_JAL;
                end
                S_JAL: begin
                    // Target from ALUOUT into PC while the ALU forms the link
                    result_src = RES_ALUOUT;
                    pc_we      = 1'b1;
                    alu_src_a  = SRC_A_OLDPC;
                    alu_src_b  = SRC_B_FOUR;
                    state_next = S_ALUWB;
                end
                S_JALR: begin
                    alu_src_a  = SRC_A_RD1;
                    alu_src_b  = SRC_B_IMM;
                    imm_src    = IMM_I;
                    state_next = S_JAL;
                end
                S_LUI: begin
                    alu_src_a  = SRC_A_ZERO;
                    alu_src_b  = SRC_B_IMM;
                    imm_src    = IMM_U;
                    state_next = S_ALUWB;
                end
                S_AUIPC: begin
                    alu_src_a  = SRC_A_OLDPC;
                    alu_src_b  = SRC_B_IMM;
                    imm_src    = IMM_U;
                    state_next = S_ALUWB;
                end
                S_HALT: begin
                    state_next = S_HALT;
                end
                default: begin
                    state_next = S_HALT;
                end
            endcase

            // Memory wait supervision applies to every requesting state.
            if (mem_req) begin
                if (mem_ready) begin
                    wait_cnt_next = '0;
                end else if (wait_inc == WAIT_CNT_W'(MEM_WAIT_MAX)) begin
                    timeout_set   = 1'b1;
                    state_next    = S_HALT;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
            retire_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            timeout_reg  <= timeout_reg | timeout_set;
            // Only completed instructions re-enter FETCH; FETCH never loops
            // to itself on completion, so a state change marks retirement.
            retire_reg   <= (state_next == S_FETCH) && (state_reg != S_FETCH);
        end
    end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_reg <= 1'b0;
        end else if (illegal_set) begin
            illegal_reg <= 1'b1;
        end
    end
    assign illegal_instr = illegal_reg;
`else
    assign illegal_instr = 1'b0;
`endif

    assign instr_retired = retire_reg & rst_n;
    assign mem_timeout   = timeout_reg;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_cpu_ctrl_fsm
// Self-checking bench for cpu_ctrl_fsm. Each instruction is expanded into the
// per-cycle control word it must produce, derived from the instruction class
// and the datapath step table; randomized instruction streams and memory
// latencies run against it alongside directed cases.
// ---------------------------------------------------------------------------
module tb_cpu_ctrl_fsm;
    import cpu_ctrl_fsm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        z_flag;
    logic        mem_ready;
    logic        mem_req, mem_we, adr_src, ir_we, pc_we, reg_we;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [2:0]  imm_src;
    alu_opcode_t alu_op_sel;
    logic        instr_retired, mem_timeout, illegal_instr;

    always #5 clk = ~clk;

    cpu_ctrl_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .z_flag        (z_flag),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .adr_src       (adr_src),
        .ir_we         (ir_we),
        .pc_we         (pc_we),
        .reg_we        (reg_we),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .result_src    (result_src),
        .imm_src       (imm_src),
        .alu_op_sel    (alu_op_sel),
        .instr_retired (instr_retired),
        .mem_timeout   (mem_timeout),
        .illegal_instr (illegal_instr)
    );

    // Strobe bits: {mem_req, mem_we, adr_src, ir_we, pc_we, reg_we, instr_retired}
    localparam logic [6:0] ST_REQ = 7'b1000000;
    localparam logic [6:0] ST_WE  = 7'b0100000;
    localparam logic [6:0] ST_ADR = 7'b0010000;
    localparam logic [6:0] ST_IR  = 7'b0001000;
    localparam logic [6:0] ST_PC  = 7'b0000100;
    localparam logic [6:0] ST_REG = 7'b0000010;
    localparam logic [6:0] ST_RET = 7'b0000001;
    localparam logic [6:0] ST_0   = 7'b0000000;

    localparam logic [1:0] A_PC = 2'd0, A_OLD = 2'd1, A_RD1 = 2'd2, A_ZERO = 2'd3;
    localparam logic [1:0] B_RD2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2;
    localparam logic [1:0] R_OUT = 2'd0, R_DATA = 2'd1, R_ALU = 2'd2;
    localparam logic [2:0] I_I = 3'd0, I_S = 3'd1, I_B = 3'd2, I_J = 3'd3, I_U = 3'd4;
    localparam logic [19:0] IDLE = 20'd0;

    // Arithmetic op by funct3 before the SUB/SRA refinements
    alu_opcode_t arith_tab [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                   ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    // Branch compare op and whether the branch is taken when z=1
    alu_opcode_t br_tab    [8] = '{ALU_SUB, ALU_SUB, ALU_ADD, ALU_ADD,
                                   ALU_SLT, ALU_SLT, ALU_SLTU, ALU_SLTU};
    bit          br_on_zero[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [6:0]  op_tab   [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                   7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                   7'b0010111, 7'h7F};

    int   checks   = 0;
    int   failures = 0;
    logic exp_timeout = 1'b0;
    logic exp_illegal = 1'b0;
    bit   retire_due  = 1'b0;

    wire [21:0] obs = {mem_req, mem_we, adr_src, ir_we, pc_we, reg_we, instr_retired,
                       alu_src_a, alu_src_b, result_src, imm_src, alu_op_sel,
                       mem_timeout, illegal_instr};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] pk(input logic [6:0] s, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] r,
                                       input logic [2:0] i, input alu_opcode_t op);
        return {s, a, b, r, i, op};
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit model_legal(input logic [6:0] op, input logic [2:0] f3);
        if (op == 7'b0000011 || op == 7'b0100011) return f3 == 3'd2;
        if (op == 7'b1100011) return !(f3 == 3'd2 || f3 == 3'd3);
        return op inside {7'b0110011, 7'b0010011, 7'b1101111, 7'b1100111,
                          7'b0110111, 7'b0010111};
    endfunction

    function automatic alu_opcode_t exp_alu(input logic [2:0] f3, input logic f7, input bit rtype);
        if (f3 == 3'd0 && rtype && f7) return ALU_SUB;
        if (f3 == 3'd5 && f7) return ALU_SRA;
        return arith_tab[f3];
    endfunction

    // One clock: drive mem_ready, compare at the falling edge, step past the rising edge
    task automatic cyc(input string tag, input logic [19:0] e, input logic rdy);
        mem_ready = rdy;
        @(negedge clk);
        check(tag, 32'(obs), 32'({e, exp_timeout, exp_illegal}));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        cyc({tag, ":reset"}, IDLE, rnd_bit());
        rst_n       = 1'b1;
        exp_timeout = 1'b0;
        exp_illegal = 1'b0;
        retire_due  = 1'b0;
    endtask

    task automatic mem_phase(input string tag, input logic [19:0] e, input int waits);
        for (int i = 0; i < waits; i++) cyc({tag, "_wait"}, e, 1'b0);
        cyc(tag, e, 1'b1);
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input int fw, input int mw);
        string      t;
        logic [6:0] r;
        logic [19:0] wb;
        logic [19:0] jal;
        t   = $sformatf("op%02h_f3%0d_f7%0d", op, f3, f7);
        wb  = pk(ST_REG, 2'd0, 2'd0, R_OUT, 3'd0, ALU_ADD);
        jal = pk(ST_PC, A_OLD, B_FOUR, R_OUT, 3'd0, ALU_ADD);
        opcode   = op;
        funct3   = f3;
        funct7b5 = f7;
        z_flag   = z;
        r = retire_due ? ST_RET : ST_0;
        for (int i = 0; i < fw; i++)
            cyc({t, ":fetch_wait"}, pk((i == 0) ? (ST_REQ | r) : ST_REQ,
                                       2'd0, 2'd0, 2'd0, 3'd0, ALU_ADD), 1'b0);
        cyc({t, ":fetch"}, pk((fw == 0) ? (ST_REQ | ST_IR | ST_PC | r) : (ST_REQ | ST_IR | ST_PC),
                              A_PC, B_FOUR, R_ALU, 3'd0, ALU_ADD), 1'b1);
        retire_due = 1'b1;
        cyc({t, ":decode"}, pk(ST_0, A_OLD, B_IMM, R_OUT, I_B, ALU_ADD), rnd_bit());
        if (!model_legal(op, f3)) begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            exp_illegal = 1'b1;
            cyc({t, ":illegal_halt"}, IDLE, 1'b1);
            do_reset(t);
`endif
            return;
        end
        case (op)
            7'b0000011: begin
                cyc({t, ":memadr"}, pk(ST_0, A_RD1, B_IMM, R_OUT, I_I, ALU_ADD), rnd_bit());
                mem_phase({t, ":memread"}, pk(ST_REQ | ST_ADR, 2'd0, 2'd0, R_OUT, 3'd0, ALU_ADD), mw);
                cyc({t, ":memwb"}, pk(ST_REG, 2'd0, 2'd0, R_DATA, 3'd0, ALU_ADD), rnd_bit());
            end
            7'b0100011: begin
                cyc({t, ":memadr"}, pk(ST_0, A_RD1, B_IMM, R_OUT, I_S, ALU_ADD), rnd_bit());
                mem_phase({t, ":memwrite"}, pk(ST_REQ | ST_WE | ST_ADR, 2'd0, 2'd0, R_OUT, 3'd0, ALU_ADD), mw);
            end
            7'b0110011: begin
                cyc({t, ":exec_r"}, pk(ST_0, A_RD1, B_RD2, R_OUT, 3'd0, exp_alu(f3, f7, 1'b1)), rnd_bit());
                cyc({t, ":aluwb"}, wb, rnd_bit());
            end
            7'b0010011: begin
                cyc({t, ":exec_i"}, pk(ST_0, A_RD1, B_IMM, R_OUT, I_I, exp_alu(f3, f7, 1'b0)), rnd_bit());
                cyc({t, ":aluwb"}, wb, rnd_bit());
            end
            7'b1100011: begin
                cyc({t, $sformatf(":branch_z%0d", z)},
                    pk(((br_on_zero[f3] ? z : !z) ? ST_PC : ST_0), A_RD1, B_RD2, R_OUT, 3'd0, br_tab[f3]),
                    rnd_bit());
            end
            7'b1101111: begin
                cyc({t, ":jal_pre"}, pk(ST_0, A_OLD, B_IMM, R_OUT, I_J, ALU_ADD), rnd_bit());
                cyc({t, ":jal"}, jal, rnd_bit());
                cyc({t, ":aluwb"}, wb, rnd_bit());
            end
            7'b1100111: begin
                cyc({t, ":jalr"}, pk(ST_0, A_RD1, B_IMM, R_OUT, I_I, ALU_ADD), rnd_bit());
                cyc({t, ":jal"}, jal, rnd_bit());
                cyc({t, ":aluwb"}, wb, rnd_bit());
            end
            7'b0110111: begin
                cyc({t, ":lui"}, pk(ST_0, A_ZERO, B_IMM, R_OUT, I_U, ALU_ADD), rnd_bit());
                cyc({t, ":aluwb"}, wb, rnd_bit());
            end
            default: begin
                cyc({t, ":auipc"}, pk(ST_0, A_OLD, B_IMM, R_OUT, I_U, ALU_ADD), rnd_bit());
                cyc({t, ":aluwb"}, wb, rnd_bit());
            end
        endcase
    endtask

    initial begin
        int         k;
        logic [2:0] f3;
        rst_n     = 1'b0;
        opcode    = 7'd0;
        funct3    = 3'd0;
        funct7b5  = 1'b0;
        z_flag    = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        // Outputs idle while held in reset, even with mem_ready high
        cyc("reset_hold", IDLE, 1'b1);
        do_reset("init");

        // add x3,x1,x2 ; sub ; srai ; addi with instr[30]=1
        run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr(7'b0110011, 3'd0, 1'b1, 1'b0, 0, 0);
        run_instr(7'b0010011, 3'd5, 1'b1, 1'b0, 0, 0);
        run_instr(7'b0010011, 3'd0, 1'b1, 1'b0, 0, 0);
        // lw with three wait cycles in MEMREAD; sw with waits
        run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 1, 3);
        run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 0, 2);
        // BNE z=0 taken; BGE z=0 not taken; BEQ z=1 taken
        run_instr(7'b1100011, 3'd1, 1'b0, 1'b0, 0, 0);
        run_instr(7'b1100011, 3'd5, 1'b0, 1'b0, 0, 0);
        run_instr(7'b1100011, 3'd0, 1'b0, 1'b1, 0, 0);
        run_instr(7'b1101111, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr(7'b1100111, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr(7'b0110111, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr(7'b0010111, 3'd0, 1'b0, 1'b0, 0, 0);
        // Unknown opcode
        run_instr(7'h7F, 3'd0, 1'b0, 1'b0, 0, 0);

        // Reset in the middle of a waiting load drops mem_req immediately
        opcode = 7'b0000011; funct3 = 3'd2; funct7b5 = 1'b0;
        cyc("midrst:fetch", pk(ST_REQ | ST_IR | ST_PC | (retire_due ? ST_RET : ST_0),
                               A_PC, B_FOUR, R_ALU, 3'd0, ALU_ADD), 1'b1);
        cyc("midrst:decode", pk(ST_0, A_OLD, B_IMM, R_OUT, I_B, ALU_ADD), 1'b0);
        cyc("midrst:memadr", pk(ST_0, A_RD1, B_IMM, R_OUT, I_I, ALU_ADD), 1'b0);
        cyc("midrst:memread_wait", pk(ST_REQ | ST_ADR, 2'd0, 2'd0, R_OUT, 3'd0, ALU_ADD), 1'b0);
        do_reset("midrst");

        // A long but accepted wait must not shorten the next timeout window
        run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 0, 100);
        opcode = 7'b0110011;
        for (int i = 0; i < 255; i++)
            cyc("timeout:fetch_wait", pk((i == 0) ? (ST_REQ | ST_RET) : ST_REQ,
                                         2'd0, 2'd0, 2'd0, 3'd0, ALU_ADD), 1'b0);
        exp_timeout = 1'b1;
        cyc("timeout:halt", IDLE, 1'b1);
        cyc("timeout:halt_stays", IDLE, 1'b1);
        do_reset("timeout");
        cyc("post_timeout:fetch", pk(ST_REQ | ST_IR | ST_PC, A_PC, B_FOUR, R_ALU, 3'd0, ALU_ADD), 1'b1);
        cyc("post_timeout:decode", pk(ST_0, A_OLD, B_IMM, R_OUT, I_B, ALU_ADD), 1'b0);
        do_reset("post_timeout");

        // Randomized instruction stream with random memory latencies
        for (int n = 0; n < 160; n++) begin
            k  = $urandom_range(0, 9);
            f3 = 3'($urandom_range(0, 7));
            if (k < 2 && $urandom_range(0, 3) != 0) f3 = 3'd2;
            run_instr(op_tab[k], f3, rnd_bit(), rnd_bit(),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
